curve_const_loader: RTL and testbench
=====================================

# curve_const_loader

Writable bank for the secp256k1 curve constants that the point-arithmetic datapath reads as P, A (generator x) and B (generator y). Out of reset it drives the standard secp256k1 values. A host can overwrite any one constant by streaming it in as 32-bit words over a valid/ready write channel. Each new value is assembled in a shadow register and copied to the live output only once the whole frame has been received, so a constant is never updated partially.

## Interface
- `WORD_W`, default 32: write word width. Must divide 256. `NWORDS = 256/WORD_W` (8 at the default).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: the host is presenting a word.
- `wr_ready` out 1: the block can accept a word.
- `wr_sel` in 2: constant to write. 0 = P, 1 = A, 2 = B, 3 = reserved.
- `wr_data` in WORD_W: word payload. Words are sent least-significant word first.
- `wr_last` in 1: marks the final word of a frame.
- `P_const` out 256 signed: live prime.
- `A_const` out 256 signed: live generator x.
- `B_const` out 256 signed: live generator y.
- `carry_in_n` out 1: constant 0.
- `carry_in_2` out 1: constant 1.
- `upd` out 1: one-cycle pulse after a live constant changes.
- `err` out 1: one-cycle pulse after a frame is rejected.
- `busy` out 1: high while a frame is in progress.

## Operation
- **Reset values.**
  - P = FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
  - A = 79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798
  - B = 483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8
  - upd = err = busy = 0; wr_ready = 1; state IDLE; word count = 0; shadow = 0.
- **Beat.** A beat is accepted on any edge where `wr_valid & wr_ready` is high.
- **Shadow fill.** Beat number i (counting from 0) writes `shadow[i*WORD_W +: WORD_W]`.
- **State machine:**
  - IDLE → LOAD on the first accepted beat. `wr_sel` is latched on this beat; `wr_sel` on later beats of the same frame is ignored.
  - LOAD stays in LOAD while beats arrive with count < NWORDS-1 and `wr_last` = 0.
  - LOAD or IDLE → COMMIT when the accepted beat has count = NWORDS-1, `wr_last` = 1, and the latched sel ≠ 3.
  - → REJECT when any of the following holds:
    - `wr_last` = 1 with count < NWORDS-1 (short frame);
    - `wr_last` = 0 with count = NWORDS-1 (long frame);
    - a complete frame arrives with sel = 3.
  - COMMIT: copy the shadow into the selected live register; the next state is IDLE and `upd` = 1 in that cycle.
  - REJECT: live registers untouched; the next state is IDLE and `err` = 1 in that cycle.
- **Single-beat frames.** With NWORDS = 1, the IDLE → COMMIT/REJECT rules apply directly to the first beat.
- **Counter.** The word count resets to 0 when the block enters IDLE.
- **Shadow.** The shadow is not cleared between frames; every word is overwritten by a complete frame.
- **Stalls.** Idle cycles (`wr_valid` = 0) inside a frame are allowed; they do not advance state and have no timeout.
- **Outputs.** `busy` = 1 in LOAD, COMMIT and REJECT. The live outputs are registers; only COMMIT and `rst` change them.
- **Reset mid-frame.** The frame is discarded, live constants return to the defaults, and no `upd` or `err` pulse is generated.
- **Reset priority.** If `rst` and an accepted beat occur on the same edge, `rst` wins.

## Timing
- `wr_ready` = 1 in IDLE and LOAD, and 0 in COMMIT and REJECT. `wr_ready` depends only on state, never combinationally on `wr_valid`.
- Last beat accepted at edge k:
  - COMMIT/REJECT occupies cycle k→k+1.
  - The live register and `upd`/`err` change at edge k+1.
  - `wr_ready` returns to 1 in the cycle after edge k+1.
- Minimum frame-to-frame spacing is NWORDS+1 cycles (8 beats + 1 dead cycle at default).
- New values are visible on the output ports from edge k+1 onward; there is no combinational path from the write inputs to the outputs.

## Test plan
- **Reset.** Hold `rst` for 2 cycles → P/A/B equal the reset hex values above, `carry_in_n` = 0, `carry_in_2` = 1, `wr_ready` = 1, upd = err = busy = 0.
- **Load P.** Back-to-back words 0x00000001, 0x0…0 ×6, then 0x80000000 with `wr_last`, sel = 0 → P = 0x80000000_00…00_00000001 one edge after the last beat, `upd` high for exactly 1 cycle, A and B unchanged, `wr_ready` low for exactly 1 cycle.
- **Short frame.** sel = 1 with `wr_last` on beat 3 → `err` pulses once and A keeps its reset value. A following valid 8-word A frame (0xAAAAAAAA ×8) commits as A = 0xAAAA…AAAA.
- **Reserved select.** sel = 3 full frame → `err` pulse, no constant changes. Separately, sel = 2 on the first beat with sel changed to 0 on later beats → B is written and P is unchanged.
- **Backpressure and gaps.** Random `wr_valid` gaps during a B load (0x11111111…0x88888888, LSW first) → B = 0x88888888_77777777_…_11111111. No beat is captured while `wr_ready` = 0.
- **Reset mid-frame.** Assert `rst` after beat 5 of a P load that follows a committed P change → P returns to FFFF…FC2F, busy = 0, no `upd`. A fresh full frame afterwards commits normally.

Source files
------------

// File: rtl/curve_const_loader_if.sv
// curve_const_loader_if: word-serial write channel
// for the curve constant bank.
interface curve_const_loader_if #(
  parameter int WORD_W = 32
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_sel;
  logic [WORD_W-1:0] wr_data;
  logic              wr_last;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_data,
    output wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_data,
    input  wr_last,
    output wr_ready
  );
endinterface

// File: rtl/curve_const_loader.sv
// curve_const_loader: secp256k1 P/A/B bank with
// framed, all-or-nothing word-serial updates.
module curve_const_loader #(
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  curve_const_loader_if.slave wr,
  output logic signed [255:0] P_const,
  output logic signed [255:0] A_const,
  output logic signed [255:0] B_const,
  output logic                carry_in_n,
  output logic                carry_in_2,
  output logic                upd,
  output logic                err,
  output logic                busy
);
  localparam int NWORDS = 256 / WORD_W;
  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [255:0] P_RST =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] A_RST =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] B_RST =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT,
    REJECT
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [CW-1:0] cnt;
  logic [1:0]   sel_q;
  logic [1:0]   sel_eff;
  logic [255:0] shadow;
  logic         beat;
  logic         at_end;

  assign carry_in_n  = 1'b0;
  assign carry_in_2  = 1'b1;
  assign wr.wr_ready = (state == IDLE) || (state == LOAD);
  assign busy        = (state != IDLE);
  assign beat        = wr.wr_valid & wr.wr_ready;
  assign at_end      = (cnt == CW'(NWORDS - 1));
  assign sel_eff     = (state == IDLE) ? wr.wr_sel : sel_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Frame sequencing: a frame ends on wr_last or on
  // its NWORDS-th beat; only an exact-length frame to
  // a real constant commits.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, LOAD: begin
        if (beat) begin
          if (wr.wr_last && at_end)
            state_n = (sel_eff == 2'd3) ? REJECT : COMMIT;
          else if (wr.wr_last || at_end)
            state_n = REJECT;
          else
            state_n = LOAD;
        end
      end
      COMMIT, REJECT: state_n = IDLE;
      default:        state_n = IDLE;
    endcase
  end

  // Beat capture into the shadow; count clears on
  // any exit from the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sel_q  <= 2'd0;
      shadow <= '0;
    end else begin
      if (beat) begin
        shadow[int'(cnt) * WORD_W +: WORD_W] <= wr.wr_data;
        if (state == IDLE) sel_q <= wr.wr_sel;
      end
      if (state_n == LOAD) begin
        if (beat) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Live constants and status pulses change only on
  // the edge that leaves COMMIT or REJECT.
  always_ff @(posedge clk) begin
    if (rst) begin
      P_const <= P_RST;
      A_const <= A_RST;
      B_const <= B_RST;
      upd     <= 1'b0;
      err     <= 1'b0;
    end else begin
      upd <= (state == COMMIT);
      err <= (state == REJECT);
      if (state == COMMIT) begin
        case (sel_q)
          2'd0:    P_const <= shadow;
          2'd1:    A_const <= shadow;
          2'd2:    B_const <= shadow;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_curve_const_loader.sv
// tb_curve_const_loader: frame-level model plus
// directed frames with literal expectations.
module tb_curve_const_loader;
  localparam int NW = 8;
  localparam logic [255:0] P_DEF =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] A_DEF =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] B_DEF =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [255:0] P_const, A_const, B_const;
  logic carry_in_n, carry_in_2, upd, err, busy;

  curve_const_loader_if #(.WORD_W(32)) bus ();

  curve_const_loader #(.WORD_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (bus),
    .P_const    (P_const),
    .A_const    (A_const),
    .B_const    (B_const),
    .carry_in_n (carry_in_n),
    .carry_in_2 (carry_in_2),
    .upd        (upd),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  bit en = 1'b0;
  logic [31:0] w [NW];

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Frame-level model: words collect in a queue; a
  // frame resolves when wr_last arrives or it is full,
  // then takes one dead cycle before the result shows.
  logic [255:0] m_P, m_A, m_B, pend_val;
  logic m_upd, m_err, m_busy, m_ready;
  int pend = 0;
  logic [1:0] fsel;
  logic [31:0] words [$];

  task automatic model_step();
    if (rst) begin
      m_P = P_DEF; m_A = A_DEF; m_B = B_DEF;
      m_upd = 0; m_err = 0; m_busy = 0; m_ready = 1;
      pend = 0;
      words.delete();
    end else if (pend != 0) begin
      if (pend == 1) begin
        if (fsel == 2'd0) m_P = pend_val;
        if (fsel == 2'd1) m_A = pend_val;
        if (fsel == 2'd2) m_B = pend_val;
      end
      m_upd = (pend == 1);
      m_err = (pend == 2);
      pend = 0; m_busy = 0; m_ready = 1;
    end else begin
      m_upd = 0; m_err = 0;
      if (bus.wr_valid) begin
        if (words.size() == 0) fsel = bus.wr_sel;
        words.push_back(bus.wr_data);
        m_busy = 1;
        if (bus.wr_last || words.size() == NW) begin
          if (bus.wr_last && words.size() == NW && fsel != 2'd3) begin
            pend = 1;
            for (int i = 0; i < NW; i++)
              pend_val[i*32 +: 32] = words[i];
          end else begin
            pend = 2;
          end
          words.delete();
          m_ready = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (en) begin
      chk("P", P_const, m_P);
      chk("A", A_const, m_A);
      chk("B", B_const, m_B);
      chk("upd", 256'(upd), 256'(m_upd));
      chk("err", 256'(err), 256'(m_err));
      chk("busy", 256'(busy), 256'(m_busy));
      chk("ready", 256'(bus.wr_ready), 256'(m_ready));
      if (upd === 1'b1) upd_cnt++;
      if (err === 1'b1) err_cnt++;
    end
  end

  task automatic send(input logic [1:0] s0,
                      input logic [1:0] sn,
                      input int n,
                      input int last_idx,
                      input bit gaps);
    bit ok;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.wr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.wr_valid = 1'b1;
      bus.wr_sel   = (i == 0) ? s0 : sn;
      bus.wr_data  = w[i];
      bus.wr_last  = (i == last_idx);
      t = 0;
      do begin
        ok = bus.wr_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!ok && t < 50);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got ready=0 want ready=1");
      end
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_sel   = 2'd0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    chk("rst_P", P_const, P_DEF);
    chk("rst_A", A_const, A_DEF);
    chk("rst_B", B_const, B_DEF);
    chk("rst_cin_n", 256'(carry_in_n), 256'd0);
    chk("rst_cin_2", 256'(carry_in_2), 256'd1);
    chk("rst_ready", 256'(bus.wr_ready), 256'd1);
    chk("rst_flags", 256'({upd, err, busy}), 256'd0);

    for (int i = 0; i < NW; i++) w[i] = 32'h0;
    w[0] = 32'h00000001;
    w[7] = 32'h80000000;
    send(2'd0, 2'd0, NW, NW - 1, 1'b0);
    settle();
    chk("loadP_P", P_const,
        {32'h80000000, 192'h0, 32'h00000001});
    chk("loadP_A", A_const, A_DEF);
    chk("loadP_B", B_const, B_DEF);
    chk("loadP_upd_cnt", 256'(upd_cnt), 256'd1);

    for (int i = 0; i < NW; i++) w[i] = 32'hAAAAAAAA;
    send(2'd1, 2'd1, 4, 3, 1'b0);
    settle();
    chk("short_A", A_const, A_DEF);
    chk("short_err_cnt", 256'(err_cnt), 256'd1);
    send(2'd1, 2'd1, NW, NW - 1, 1'b0);
    settle();
    chk("fullA_A", A_const, {8{32'hAAAAAAAA}});

    for (int i = 0; i < NW; i++) w[i] = 32'h33333333;
    send(2'd3, 2'd3, NW, NW - 1, 1'b0);
    settle();
    chk("sel3_err_cnt", 256'(err_cnt), 256'd2);
    chk("sel3_B", B_const, B_DEF);

    send(2'd0, 2'd0, NW, -1, 1'b0);
    settle();
    chk("long_err_cnt", 256'(err_cnt), 256'd3);
    chk("long_P", P_const,
        {32'h80000000, 192'h0, 32'h00000001});

    for (int i = 0; i < NW; i++) w[i] = 32'h0B0B0000 + 32'(i);
    send(2'd2, 2'd0, NW, NW - 1, 1'b0);
    settle();
    chk("selchg_B", B_const,
        256'h0B0B0007_0B0B0006_0B0B0005_0B0B0004_0B0B0003_0B0B0002_0B0B0001_0B0B0000);
    chk("selchg_P", P_const,
        {32'h80000000, 192'h0, 32'h00000001});

    for (int i = 0; i < NW; i++) w[i] = 32'h11111111 * 32'(i + 1);
    send(2'd2, 2'd2, NW, NW - 1, 1'b1);
    settle();
    chk("gaps_B", B_const,
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);

    send(2'd0, 2'd0, 5, -1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_P", P_const, P_DEF);
    chk("midrst_busy", 256'(busy), 256'd0);
    chk("midrst_upd", 256'(upd), 256'd0);
    settle();
    chk("midrst_upd_cnt", 256'(upd_cnt), 256'd4);

    for (int i = 0; i < NW; i++) w[i] = 32'h12340000 + 32'(i);
    send(2'd0, 2'd0, NW, NW - 1, 1'b0);
    settle();
    chk("fresh_P", P_const,
        256'h12340007_12340006_12340005_12340004_12340003_12340002_12340001_12340000);
    chk("fresh_A", A_const, A_DEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
